// File: rtl/dtlb_pkg.sv
// Shared types and widths for the data TLB; widths line up with the victim
// cache's 44-bit physical tag.
package dtlb_pkg;

    localparam int DTLB_VPN_W = 52;
    localparam int DTLB_PPN_W = 44;

    typedef struct packed {
        logic                  valid;
        logic [DTLB_VPN_W-1:0] vpn;
        logic [DTLB_PPN_W-1:0] ppn;
    } tlb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } dtlb_state_t;

endpackage

// File: rtl/dtlb_if.sv
// Lookup, return, refill and statistics signals of the data TLB.
// master = requester/walker side, slave = TLB side.
interface dtlb_if
    import dtlb_pkg::*;
#(
    parameter int VPN_W = DTLB_VPN_W,
    parameter int PPN_W = DTLB_PPN_W
);
    logic             lookup_valid;
    logic [VPN_W-1:0] vpn;
    logic             lookup_ready;
    logic             ret_valid;
    logic [PPN_W-1:0] phys_tag_ret;
    logic             tlb_miss;
    logic             refill_req;
    logic [VPN_W-1:0] refill_vpn;
    logic             refill_valid;
    logic [PPN_W-1:0] refill_ppn;
    logic             flush;
    logic [31:0]      hit_count;
    logic [31:0]      miss_count;

    modport master (
        output lookup_valid, vpn, refill_valid, refill_ppn, flush,
        input  lookup_ready, ret_valid, phys_tag_ret, tlb_miss,
               refill_req, refill_vpn, hit_count, miss_count
    );

    modport slave (
        input  lookup_valid, vpn, refill_valid, refill_ppn, flush,
        output lookup_ready, ret_valid, phys_tag_ret, tlb_miss,
               refill_req, refill_vpn, hit_count, miss_count
    );
endinterface

// File: rtl/dtlb_victim_sel.sv
// Refill victim choice: lowest-index free entry, otherwise the round-robin
// pointer, which only advances when it actually supplied the victim.
module dtlb_victim_sel #(
    parameter int ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ENTRIES-1:0]         valid_vec,
    input  logic                       flush,
    input  logic                       alloc,
    output logic [$clog2(ENTRIES)-1:0] victim_idx
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        victim_idx = free_found ? free_idx : ptr_q;
    end

    // ENTRIES is a power of two, so the increment wraps on its own.
    always_comb begin
        ptr_d = ptr_q;
        if (flush)                   ptr_d = '0;
        else if (alloc && !free_found) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/register.sv
// Generic width-parameterised register with synchronous active-high reset
// and write enable.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)         q <= '0;
        else if (write_en) q <= d;
    end
endmodule

// File: rtl/dtlb_lookup.sv
// Fully-associative data TLB: one-cycle-late translation result plus a
// miss-driven refill walk. Define DTLB_STATS_EN to build hit/miss counters.
module dtlb_lookup
    import dtlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int VPN_W   = DTLB_VPN_W,
    parameter int PPN_W   = DTLB_PPN_W
) (
    input logic   clk,
    input logic   reset,
    dtlb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    tlb_entry_t [ENTRIES-1:0] entries_q, entries_d;
    dtlb_state_t              state_q, state_d;
    logic [VPN_W-1:0]         refill_vpn_q, refill_vpn_d;

    logic                     accept, hit_any, hit_eff, install;
    logic [IDX_W-1:0]         hit_idx, victim_idx;
    logic [ENTRIES-1:0]       valid_vec;

    logic                     ret_valid_d, ret_valid_q;
    logic                     tlb_miss_d, tlb_miss_q;
    logic [PPN_W-1:0]         phys_tag_d, phys_tag_q;

    assign accept = bus.lookup_valid && (state_q == IDLE);

    // Lowest matching index wins if duplicates ever appear.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entries_q[i].valid && entries_q[i].vpn == bus.vpn) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // A lookup coinciding with flush must not see the entries being cleared.
    assign hit_eff = accept && hit_any && !bus.flush;

    always_comb begin
        ret_valid_d = accept;
        tlb_miss_d  = accept && !hit_eff;
        phys_tag_d  = hit_eff ? entries_q[hit_idx].ppn : '0;
    end

    always_comb begin
        state_d      = state_q;
        refill_vpn_d = refill_vpn_q;
        install      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !hit_eff) begin
                    state_d      = WALK;
                    refill_vpn_d = bus.vpn;
                end
            end
            WALK: begin
                if (bus.refill_valid) begin
                    install = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Victim selection sees post-flush validity so flush+refill lands in entry 0.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) valid_vec[i] = entries_q[i].valid && !bus.flush;
    end

    dtlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
        .clk        (clk),
        .reset      (reset),
        .valid_vec  (valid_vec),
        .flush      (bus.flush),
        .alloc      (install),
        .victim_idx (victim_idx)
    );

    always_comb begin
        entries_d = entries_q;
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
        end
        if (install) begin
            entries_d[victim_idx].valid = 1'b1;
            entries_d[victim_idx].vpn   = refill_vpn_q;
            entries_d[victim_idx].ppn   = bus.refill_ppn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            refill_vpn_q <= '0;
            entries_q    <= '0;
        end else begin
            state_q      <= state_d;
            refill_vpn_q <= refill_vpn_d;
            entries_q    <= entries_d;
        end
    end

    register #(.WIDTH(1)) u_ret_valid_reg (
        .clk(clk), .reset(reset), .write_en(1'b1), .d(ret_valid_d), .q(ret_valid_q)
    );
    register #(.WIDTH(1)) u_tlb_miss_reg (
        .clk(clk), .reset(reset), .write_en(1'b1), .d(tlb_miss_d), .q(tlb_miss_q)
    );
    register #(.WIDTH(PPN_W)) u_phys_tag_reg (
        .clk(clk), .reset(reset), .write_en(1'b1), .d(phys_tag_d), .q(phys_tag_q)
    );

    assign bus.ret_valid    = ret_valid_q;
    assign bus.tlb_miss     = tlb_miss_q;
    assign bus.phys_tag_ret = phys_tag_q;
    assign bus.lookup_ready = (state_q == IDLE);
    assign bus.refill_req   = (state_q == WALK);
    assign bus.refill_vpn   = refill_vpn_q;

`ifdef DTLB_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_eff && hit_count_q != 32'hFFFF_FFFF)
            hit_count_d = hit_count_q + 32'd1;
        if (tlb_miss_d && miss_count_q != 32'hFFFF_FFFF)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_dtlb_lookup.sv
// Randomised + directed bench for dtlb_lookup against a translation-table model.
module tb_dtlb_lookup;
    localparam int N     = 16;
    localparam int VPN_W = 52;
    localparam int PPN_W = 44;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dtlb_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) bus ();

    dtlb_lookup #(.ENTRIES(N), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a table of translations ----------------
    bit               m_v   [N];
    logic [VPN_W-1:0] m_vpn [N];
    logic [PPN_W-1:0] m_ppn [N];
    int               m_ptr;
    bit               m_walk;
    logic [VPN_W-1:0] m_rvpn;
    int               m_hits, m_misses;
    bit               started = 1'b0;

    bit               e_ret, e_miss;
    logic [PPN_W-1:0] e_tag;

    always @(posedge clk) begin
        int  hi, vi;
        bit  acc, hit;
        if (reset) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_ptr = 0; m_walk = 1'b0; m_rvpn = '0;
            m_hits = 0; m_misses = 0;
            e_ret = 1'b0; e_miss = 1'b0; e_tag = '0;
            started = 1'b1;
        end else begin
            hi = -1;
            for (int i = 0; i < N; i++)
                if (hi < 0 && m_v[i] && m_vpn[i] == bus.vpn) hi = i;
            acc    = bus.lookup_valid && !m_walk;
            hit    = acc && (hi >= 0) && !bus.flush;
            e_ret  = acc;
            e_miss = acc && !hit;
            e_tag  = hit ? m_ppn[hi] : '0;
            if (hit && m_hits != -1)        m_hits++;
            if (e_miss && m_misses != -1)   m_misses++;
            if (bus.flush) begin
                for (int i = 0; i < N; i++) m_v[i] = 1'b0;
                m_ptr = 0;
            end
            if (m_walk && bus.refill_valid) begin
                vi = -1;
                for (int i = 0; i < N; i++) if (vi < 0 && !m_v[i]) vi = i;
                if (vi < 0) begin
                    vi    = m_ptr;
                    m_ptr = (m_ptr + 1) % N;
                end
                m_v[vi]   = 1'b1;
                m_vpn[vi] = m_rvpn;
                m_ppn[vi] = bus.refill_ppn;
                m_walk    = 1'b0;
            end else if (e_miss) begin
                m_walk = 1'b1;
                m_rvpn = bus.vpn;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("ret_valid",    64'(bus.ret_valid),    64'(e_ret));
            chk("tlb_miss",     64'(bus.tlb_miss),     64'(e_miss));
            chk("phys_tag_ret", 64'(bus.phys_tag_ret), 64'(e_tag));
            chk("lookup_ready", 64'(bus.lookup_ready), 64'(!m_walk));
            chk("refill_req",   64'(bus.refill_req),   64'(m_walk));
            chk("refill_vpn",   64'(bus.refill_vpn),   64'(m_rvpn));
`ifdef DTLB_STATS_EN
            chk("hit_count",    64'(bus.hit_count),    64'(m_hits));
            chk("miss_count",   64'(bus.miss_count),   64'(m_misses));
`else
            chk("hit_count",    64'(bus.hit_count),    64'd0);
            chk("miss_count",   64'(bus.miss_count),   64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic lookup(input logic [VPN_W-1:0] v);
        bus.lookup_valid = 1'b1;
        bus.vpn          = v;
        @(negedge clk);
        bus.lookup_valid = 1'b0;
    endtask

    task automatic refill(input logic [PPN_W-1:0] p);
        bus.refill_valid = 1'b1;
        bus.refill_ppn   = p;
        @(negedge clk);
        bus.refill_valid = 1'b0;
    endtask

    task automatic access(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p);
        lookup(v);
        if (m_walk) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            refill(p);
        end
    endtask

    initial begin
        bus.lookup_valid = 1'b0;
        bus.vpn          = '0;
        bus.refill_valid = 1'b0;
        bus.refill_ppn   = '0;
        bus.flush        = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("lit_ready_after_reset", 64'(bus.lookup_ready), 64'd1);

        // first miss and walk
        lookup(52'h12345);
        chk("lit_miss_12345", 64'(bus.tlb_miss), 64'd1);
        chk("lit_req_12345",  64'(bus.refill_req), 64'd1);
        chk("lit_rvpn_12345", 64'(bus.refill_vpn), 64'h12345);
        chk("lit_ready_walk", 64'(bus.lookup_ready), 64'd0);
        repeat (2) @(negedge clk);
        refill(44'hABCDE);
        chk("lit_req_drop", 64'(bus.refill_req), 64'd0);
        lookup(52'h12345);
        chk("lit_hit_12345", 64'(bus.phys_tag_ret), 64'hABCDE);
        chk("lit_hit_miss0", 64'(bus.tlb_miss), 64'd0);

        // fill all entries, then replacement round-robin
        bus.flush = 1'b1; @(negedge clk); bus.flush = 1'b0;
        for (int i = 0; i < N; i++) access(52'h100 + 52'(i), 44'h200 + 44'(i));
        access(52'h999, 44'h9);
        access(52'h998, 44'h8);
        lookup(52'h102);
        chk("lit_keep_102", 64'(bus.phys_tag_ret), 64'h202);
        lookup(52'h999);
        chk("lit_new_999", 64'(bus.phys_tag_ret), 64'h9);
        lookup(52'h101);
        chk("lit_evict_101", 64'(bus.tlb_miss), 64'd1);
        refill(44'h301);
        lookup(52'h100);
        chk("lit_evict_100", 64'(bus.tlb_miss), 64'd1);
        refill(44'h300);

        // back-to-back hits
        bus.flush = 1'b1; @(negedge clk); bus.flush = 1'b0;
        access(52'h1, 44'h11);
        access(52'h2, 44'h22);
        access(52'h3, 44'h33);
        lookup(52'h1);
        chk("lit_b2b_1", 64'(bus.phys_tag_ret), 64'h11);
        lookup(52'h2);
        chk("lit_b2b_2", 64'(bus.phys_tag_ret), 64'h22);
        lookup(52'h3);
        chk("lit_b2b_3", 64'(bus.phys_tag_ret), 64'h33);

        // flush during walk keeps the walk
        lookup(52'h77);
        bus.flush = 1'b1; @(negedge clk); bus.flush = 1'b0;
        chk("lit_walk_kept", 64'(bus.refill_req), 64'd1);
        refill(44'h55);
        lookup(52'h77);
        chk("lit_refill_77", 64'(bus.phys_tag_ret), 64'h55);
        lookup(52'h2);
        chk("lit_flushed_2", 64'(bus.tlb_miss), 64'd1);
        refill(44'h22);

        // flush and refill in the same cycle
        lookup(52'h66);
        bus.flush = 1'b1;
        refill(44'h66);
        bus.flush = 1'b0;
        lookup(52'h66);
        chk("lit_flush_refill", 64'(bus.phys_tag_ret), 64'h66);

        // lookup coinciding with flush
        bus.flush = 1'b1;
        lookup(52'h66);
        bus.flush = 1'b0;
        chk("lit_flush_lookup", 64'(bus.tlb_miss), 64'd1);
        refill(44'h67);

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            reset            = ($urandom_range(0, 149) == 0);
            bus.lookup_valid = $urandom_range(0, 1) == 1;
            bus.vpn          = 52'h1000 + 52'($urandom_range(0, 23));
            bus.refill_valid = ($urandom_range(0, 3) == 0);
            bus.refill_ppn   = {12'($urandom()), 32'($urandom())};
            bus.flush        = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        reset = 1'b0; bus.lookup_valid = 1'b0; bus.refill_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);

        // reset mid-walk, then statistics
        if (!m_walk) lookup(52'h4444);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("lit_rst_req",   64'(bus.refill_req), 64'd0);
        chk("lit_rst_ready", 64'(bus.lookup_ready), 64'd1);
        refill(44'h99);
        chk("lit_late_refill", 64'(bus.refill_req), 64'd0);
        lookup(52'h4444);
        chk("lit_rst_miss", 64'(bus.tlb_miss), 64'd1);
        refill(44'h44);
        for (int i = 0; i < 3; i++) lookup(52'h4444);
        access(52'h5555, 44'h55);
`ifdef DTLB_STATS_EN
        chk("lit_hit_count",  64'(bus.hit_count), 64'd3);
        chk("lit_miss_count", 64'(bus.miss_count), 64'd2);
`else
        chk("lit_hit_count",  64'(bus.hit_count), 64'd0);
        chk("lit_miss_count", 64'(bus.miss_count), 64'd0);
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
